// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: architectural register numbers and the
// default register-file geometry.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

endpackage : mips_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for pending loads. It provides the registered
// busy vector and the per-read-port busy lookup.
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bset,
    input  logic [ADDR_W-1:0]          bset_a,
    input  logic                       bflush,
    input  logic                       wen1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [NUM_RD-1:0]          ren,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic [(1<<ADDR_W)-1:0]     busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy state: flush beats set, and set beats the load-writeback clear.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (bflush) begin
                busy_d[i] = 1'b0;
            end else if (ZERO_REG != 0 && i == REG_ZERO) begin
                busy_d[i] = 1'b0;
            end else if (bset && bset_a == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end else if (wen1 && wa1 == ADDR_W'(i)) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // Busy vector register, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_busy
        logic [ADDR_W-1:0] addr_s;
        logic              flag_s;

        assign addr_s = ra[k*ADDR_W +: ADDR_W];

        // A load landing on this address this cycle is forwarded, so it is not a stall.
        always_comb begin
            if (!ren[k]) begin
                flag_s = 1'b0;
            end else if (ZERO_REG != 0 && addr_s == ADDR_W'(REG_ZERO)) begin
                flag_s = 1'b0;
            end else if (BYPASS != 0 && wen1 && wa1 == addr_s) begin
                flag_s = 1'b0;
            end else begin
                flag_s = busy_q[addr_s];
            end
        end

        assign rd_busy[k] = flag_s;
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Parametrised multi-port MIPS register file: two write ports (ALU and load),
// NUM_RD combinational read ports with optional same-cycle bypass.
module regfile_mp
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       wen1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic [NUM_RD-1:0]          ren,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       bset,
    input  logic [ADDR_W-1:0]          bset_a,
    input  logic                       bflush,
    output logic [(1<<ADDR_W)-1:0]     busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              w0_ok_s;
    logic              w1_ok_s;

    // A write to the hardwired zero register is dropped at the source.
    assign w0_ok_s = wen0 && !(ZERO_REG != 0 && wa0 == ADDR_W'(REG_ZERO));
    assign w1_ok_s = wen1 && !(ZERO_REG != 0 && wa1 == ADDR_W'(REG_ZERO));

    // Write arbitration: the load port wins an address collision.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (w1_ok_s && wa1 == ADDR_W'(i)) begin
                mem_d[i] = wd1;
            end else if (w0_ok_s && wa0 == ADDR_W'(i)) begin
                mem_d[i] = wd0;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Register storage, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;

        assign addr_s = ra[k*ADDR_W +: ADDR_W];

        // Read mux: disabled/zero reads give 0, then load bypass, ALU bypass, storage.
        always_comb begin
            if (!ren[k]) begin
                data_s = '0;
            end else if (ZERO_REG != 0 && addr_s == ADDR_W'(REG_ZERO)) begin
                data_s = '0;
            end else if (BYPASS != 0 && w1_ok_s && wa1 == addr_s) begin
                data_s = wd1;
            end else if (BYPASS != 0 && w0_ok_s && wa0 == addr_s) begin
                data_s = wd0;
            end else begin
                data_s = mem_q[addr_s];
            end
        end

        assign rd[k*DATA_W +: DATA_W] = data_s;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .bset    (bset),
        .bset_a  (bset_a),
        .bflush  (bflush),
        .wen1    (wen1),
        .wa1     (wa1),
        .ren     (ren),
        .ra      (ra),
        .rd_busy (rd_busy),
        .busy    (busy)
    );

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench: one bypassing and one non-bypassing register
// file share the same stimulus and are checked against hand-computed values.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        wen0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        wen1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  ren;
    logic [9:0]  ra;
    logic        bset;
    logic [4:0]  bset_a;
    logic        bflush;

    logic [63:0] rd_b;
    logic [63:0] rd_n;
    logic [1:0]  rdb_b;
    logic [1:0]  rdb_n;
    logic [31:0] busy_b;
    logic [31:0] busy_n;

    int n_tests;
    int n_fail;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) u_byp (
        .clk(clk), .rst(rst),
        .wen0(wen0), .wa0(wa0), .wd0(wd0),
        .wen1(wen1), .wa1(wa1), .wd1(wd1),
        .ren(ren), .ra(ra), .rd(rd_b), .rd_busy(rdb_b),
        .bset(bset), .bset_a(bset_a), .bflush(bflush), .busy(busy_b)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) u_nobyp (
        .clk(clk), .rst(rst),
        .wen0(wen0), .wa0(wa0), .wd0(wd0),
        .wen1(wen1), .wa1(wa1), .wd1(wd1),
        .ren(ren), .ra(ra), .rd(rd_n), .rd_busy(rdb_n),
        .bset(bset), .bset_a(bset_a), .bflush(bflush), .busy(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen0 = 1'b0; wen1 = 1'b0; bset = 1'b0; bflush = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (busy_b !== 32'h0) begin n_fail++; $display("FAIL reset_busy_held: got %h exp %h", busy_b, 32'h0); end
        @(negedge clk);
        rst = 1'b1; ren = 2'b11; ra = {5'd5, 5'd5};
        #1;
        n_tests++;
        if (rd_b !== 64'h0) begin n_fail++; $display("FAIL reset_rd_byp: got %h exp %h", rd_b, 64'h0); end
        n_tests++;
        if (rd_n !== 64'h0) begin n_fail++; $display("FAIL reset_rd_nobyp: got %h exp %h", rd_n, 64'h0); end
        n_tests++;
        if (rdb_b !== 2'b00 || rdb_n !== 2'b00) begin n_fail++; $display("FAIL reset_rd_busy: got %b/%b exp 00", rdb_b, rdb_n); end
        n_tests++;
        if (busy_b !== 32'h0 || busy_n !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h/%h exp 0", busy_b, busy_n); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wen0 = 1'b1; wa0 = 5'd7; wd0 = 32'hDEADBEEF; ra = {5'd5, 5'd7};
        #1;
        n_tests++;
        if (rd_n[31:0] !== 32'h0) begin n_fail++; $display("FAIL wr_same_cycle_nobyp: got %h exp %h", rd_n[31:0], 32'h0); end
        n_tests++;
        if (rd_b[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_same_cycle_byp: got %h exp %h", rd_b[31:0], 32'hDEADBEEF); end
        tick(); idle(); #1;
        n_tests++;
        if (rd_n[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_next_cycle_nobyp: got %h exp %h", rd_n[31:0], 32'hDEADBEEF); end
        n_tests++;
        if (rd_b[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_next_cycle_byp: got %h exp %h", rd_b[31:0], 32'hDEADBEEF); end
        ren = 2'b10; #1;
        n_tests++;
        if (rd_b[31:0] !== 32'h0) begin n_fail++; $display("FAIL ren_off: got %h exp %h", rd_b[31:0], 32'h0); end
        ren = 2'b11;
    endtask

    task automatic test_zero_and_bypass();
        @(negedge clk);
        wen0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234; ra = {5'd0, 5'd0};
        #1;
        n_tests++;
        if (rd_b !== 64'h0) begin n_fail++; $display("FAIL zero_bypass: got %h exp %h", rd_b, 64'h0); end
        tick(); idle(); #1;
        n_tests++;
        if (rd_b !== 64'h0 || rd_n !== 64'h0) begin n_fail++; $display("FAIL zero_stored: got %h/%h exp 0", rd_b, rd_n); end
        wen0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5; ra = {5'd3, 5'd0};
        #1;
        n_tests++;
        if (rd_b[63:32] !== 32'hA5) begin n_fail++; $display("FAIL bypass_port1: got %h exp %h", rd_b[63:32], 32'hA5); end
        n_tests++;
        if (rd_n[63:32] !== 32'h0) begin n_fail++; $display("FAIL nobypass_port1: got %h exp %h", rd_n[63:32], 32'h0); end
        tick(); idle(); #1;
        n_tests++;
        if (rd_n[63:32] !== 32'hA5) begin n_fail++; $display("FAIL stored_port1: got %h exp %h", rd_n[63:32], 32'hA5); end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        wen0 = 1'b1; wa0 = 5'd9; wd0 = 32'h11;
        wen1 = 1'b1; wa1 = 5'd9; wd1 = 32'h22;
        ra = {5'd9, 5'd9};
        #1;
        n_tests++;
        if (rd_b !== {32'h22, 32'h22}) begin n_fail++; $display("FAIL dual_bypass: got %h exp %h", rd_b, {32'h22, 32'h22}); end
        tick(); idle(); #1;
        n_tests++;
        if (rd_n[31:0] !== 32'h22) begin n_fail++; $display("FAIL dual_stored_nobyp: got %h exp %h", rd_n[31:0], 32'h22); end
        n_tests++;
        if (rd_b[31:0] !== 32'h22) begin n_fail++; $display("FAIL dual_stored_byp: got %h exp %h", rd_b[31:0], 32'h22); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        bset = 1'b1; bset_a = 5'd4; ra = {5'd0, 5'd4};
        #1;
        n_tests++;
        if (busy_b !== 32'h0) begin n_fail++; $display("FAIL busy_before_edge: got %h exp %h", busy_b, 32'h0); end
        tick(); idle(); #1;
        n_tests++;
        if (busy_b !== 32'h10 || busy_n !== 32'h10) begin n_fail++; $display("FAIL bset4: got %h/%h exp %h", busy_b, busy_n, 32'h10); end
        n_tests++;
        if (rdb_b !== 2'b01 || rdb_n !== 2'b01) begin n_fail++; $display("FAIL rd_busy4: got %b/%b exp 01", rdb_b, rdb_n); end
        wen1 = 1'b1; wa1 = 5'd4; wd1 = 32'hFF;
        #1;
        n_tests++;
        if (rdb_b !== 2'b00) begin n_fail++; $display("FAIL rd_busy_fwd_byp: got %b exp 00", rdb_b); end
        n_tests++;
        if (rdb_n !== 2'b01) begin n_fail++; $display("FAIL rd_busy_fwd_nobyp: got %b exp 01", rdb_n); end
        n_tests++;
        if (rd_b[31:0] !== 32'hFF) begin n_fail++; $display("FAIL load_bypass: got %h exp %h", rd_b[31:0], 32'hFF); end
        tick(); idle(); #1;
        n_tests++;
        if (busy_b !== 32'h0 || busy_n !== 32'h0) begin n_fail++; $display("FAIL wen1_clear: got %h/%h exp 0", busy_b, busy_n); end
        bset = 1'b1; bset_a = 5'd6; wen1 = 1'b1; wa1 = 5'd6; wd1 = 32'h66;
        tick(); idle(); #1;
        n_tests++;
        if (busy_b !== 32'h40) begin n_fail++; $display("FAIL set_beats_clear: got %h exp %h", busy_b, 32'h40); end
        bset = 1'b1; bset_a = 5'd0;
        tick(); idle(); #1;
        n_tests++;
        if (busy_b !== 32'h40) begin n_fail++; $display("FAIL busy0_held: got %h exp %h", busy_b, 32'h40); end
        bset = 1'b1; bset_a = 5'd10;
        tick(); idle(); #1;
        wen0 = 1'b1; wa0 = 5'd10; wd0 = 32'h1;
        tick(); idle(); #1;
        n_tests++;
        if (busy_b !== 32'h440) begin n_fail++; $display("FAIL wen0_no_clear: got %h exp %h", busy_b, 32'h440); end
        bflush = 1'b1; bset = 1'b1; bset_a = 5'd8;
        tick(); idle(); #1;
        n_tests++;
        if (busy_b !== 32'h0 || busy_n !== 32'h0) begin n_fail++; $display("FAIL flush: got %h/%h exp 0", busy_b, busy_n); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bset = 1'b1; bset_a = 5'd4; ra = {5'd9, 5'd4};
        tick(); idle(); #1;
        n_tests++;
        if (busy_b !== 32'h10 || rd_b[31:0] !== 32'hFF) begin n_fail++; $display("FAIL pre_reset_state: got busy %h rd %h exp 10/ff", busy_b, rd_b[31:0]); end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_tests++;
        if (busy_b !== 32'h0 || busy_n !== 32'h0) begin n_fail++; $display("FAIL async_busy: got %h/%h exp 0", busy_b, busy_n); end
        n_tests++;
        if (rd_b !== 64'h0 || rd_n !== 64'h0) begin n_fail++; $display("FAIL async_rd: got %h/%h exp 0", rd_b, rd_n); end
        n_tests++;
        if (rdb_b !== 2'b00) begin n_fail++; $display("FAIL async_rd_busy: got %b exp 00", rdb_b); end
        @(negedge clk);
        rst = 1'b1;
        tick(); #1;
        n_tests++;
        if (rd_n !== 64'h0) begin n_fail++; $display("FAIL storage_cleared: got %h exp %h", rd_n, 64'h0); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b0; wen0 = 1'b0; wa0 = '0; wd0 = '0;
        wen1 = 1'b0; wa1 = '0; wd1 = '0;
        ren = 2'b00; ra = '0; bset = 1'b0; bset_a = '0; bflush = 1'b0;
        test_reset();
        test_write_read();
        test_zero_and_bypass();
        test_dual_write();
        test_scoreboard();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp
